// File: rtl/six_bit_mul_if.sv
// Start/done handshake bundle for the sequential 6x6 multiplier.
// The master drives the operands and start; the slave returns the result and status.
interface six_bit_mul_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] prod;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, ain, bin,
        input  prod, overflow, busy, done
    );

    modport slave (
        input  start, ain, bin,
        output prod, overflow, busy, done
    );
endinterface

// File: rtl/six_bit_mul.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier, one multiplier bit per clock.
// Returns the low WIDTH bits of the product and flags any set bit above them.
//
// state | meaning
// IDLE  | waiting for start; result and flag held
// CALC  | accumulating one multiplier bit per edge
module six_bit_mul #(
    parameter int WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    six_bit_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;
    logic               last;
    logic [WIDTH-1:0]   prod_r;
    logic               overflow_r;
    logic               done_r;

    assign last     = (cnt == CW'(WIDTH - 1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            prod_r     <= '0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.ain};
                        mplier <= bus.bin;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // The final edge publishes the sum including its own partial product.
                    if (last) begin
                        prod_r     <= acc_next[WIDTH-1:0];
                        overflow_r <= |acc_next[2*WIDTH-1:WIDTH];
                        done_r     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.prod     = prod_r;
    assign bus.overflow = overflow_r;
    assign bus.done     = done_r;
    assign bus.busy     = (state == CALC);
endmodule

// File: tb/tb_six_bit_mul.sv
// Scoreboard bench for six_bit_mul: stimulus pushes (a*b)%64 and (a*b>63) into a queue,
// an independent monitor pops and compares on every done pulse.
module tb_six_bit_mul;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    six_bit_mul_if #(.WIDTH(6)) bus ();

    six_bit_mul #(.WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int p;
        int o;
    } exp_t;

    exp_t q[$];
    int   n_pass   = 0;
    int   n_chk    = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("prod", int'(bus.prod), e.p);
                check("overflow", int'(bus.overflow), e.o);
            end
        end
    end

    // Called at a negedge while idle; returns just after the accepting edge with
    // the operand inputs scrambled so only the captured values can matter.
    task automatic issue(input int a, input int b);
        exp_t e;
        bus.start = 1'b1;
        bus.ain   = 6'(a);
        bus.bin   = 6'(b);
        e.p = (a * b) % 64;
        e.o = (a * b > 63) ? 1 : 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ain   = 6'($urandom);
        bus.bin   = 6'($urandom);
    endtask

    // Waits (bounded) for done; edges counts accepting-edge-to-done edges, nb busy cycles seen.
    task automatic wait_done(output int edges, output int nb);
        int t = 0;
        nb = 0;
        do begin
            @(negedge clk);
            t++;
            if (bus.busy) nb++;
        end while (!bus.done && t < 20);
        if (!bus.done) check("done_timeout", 0, 1);
        edges = t - 1;
    endtask

    initial begin
        int lat, nb, d0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.ain   = '0;
        bus.bin   = '0;
        #23;
        check("rst_prod", int'(bus.prod), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(7, 9);
        wait_done(lat, nb);
        check("latency_edges", lat, 6);
        check("busy_cycles", nb, 6);
        @(negedge clk);
        check("done_clears", int'(bus.done), 0);
        check("prod_holds", int'(bus.prod), 63);

        issue(8, 8);   wait_done(lat, nb);
        issue(63, 63); wait_done(lat, nb);
        issue(0, 63);  wait_done(lat, nb);
        @(negedge clk);

        // A start pulse while busy must neither restart nor queue an operation.
        d0 = done_cnt;
        issue(5, 3);
        @(negedge clk);
        @(negedge clk);
        check("busy_mid_op", int'(bus.busy), 1);
        bus.start = 1'b1;
        bus.ain   = 6'd10;
        bus.bin   = 6'd10;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, nb);
        repeat (12) @(negedge clk);
        check("single_done", done_cnt - d0, 1);

        // Abort a 63*63 multiply at CALC cycle 3.
        issue(63, 63);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        d0 = done_cnt;
        check("abort_prod", int'(bus.prod), 0);
        check("abort_overflow", int'(bus.overflow), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        issue(2, 3);
        wait_done(lat, nb);

        // Exhaustive, back-to-back on each done cycle.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                issue(a, b);
                wait_done(lat, nb);
            end
        end

        // Random operands with random idle gaps.
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            wait_done(lat, nb);
            if (i == 0) check("random_latency", lat, 6);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
